// File: rtl/log_range_reduce_pkg.sv
// Shared constants and FSM state type for the log/exp range-reduction unit.
package log_range_pkg;
  localparam logic [15:0] E_Q12     = 16'h2B7E;
  localparam logic [15:0] INV_E_Q12 = 16'h05E3;
  localparam logic [15:0] ONE_Q12   = 16'h1000;
  localparam int          K_MIN     = -8;
  localparam int          K_MAX     = 7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/log_range_reduce_q12_const_mul.sv
// Combinational Q4.12 multiply by a constant; LOG_RANGE_ROUND_EN selects
// round-to-nearest instead of truncation.
module q12_const_mul #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] p
);
`ifdef LOG_RANGE_ROUND_EN
  localparam logic [2*DATA_W-1:0] RND = (2*DATA_W)'(1) << 11;
`else
  localparam logic [2*DATA_W-1:0] RND = '0;
`endif

  logic [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(c) + RND;
  assign p    = DATA_W'(prod >> 12);
endmodule

// File: rtl/log_range_reduce.sv
// Iterative range reduction x = m * e^k with m in [1, e), one scale step per cycle.
// Build option: LOG_RANGE_ROUND_EN (rounded scale steps, see q12_const_mul).
module log_range_reduce
  import log_range_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K_W-1:0]    k_out,
  output logic [DATA_W-1:0] m_out,
  output logic              zero_out,
  output logic              sat_out
);
  localparam logic [K_W-1:0]    KMIN_V = K_W'(K_MIN);
  localparam logic [K_W-1:0]    KMAX_V = K_W'(K_MAX);
  localparam logic [DATA_W-1:0] E_V    = DATA_W'(E_Q12);
  localparam logic [DATA_W-1:0] IE_V   = DATA_W'(INV_E_Q12);
  localparam logic [DATA_W-1:0] ONE_V  = DATA_W'(ONE_Q12);

  state_t            state;
  logic [DATA_W-1:0] x;
  logic [K_W-1:0]    k;
  logic              too_big, too_small;
  logic [DATA_W-1:0] x_scaled;

  assign too_big   = (x >= E_V);
  assign too_small = (x < ONE_V);

  // Single multiplier: divide by e when too big, multiply by e otherwise.
  q12_const_mul #(.DATA_W(DATA_W)) u_mul (
    .a (x),
    .c (too_big ? IE_V : E_V),
    .p (x_scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      k_out     <= '0;
      m_out     <= '0;
      zero_out  <= 1'b0;
      sat_out   <= 1'b0;
      x         <= '0;
      k         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x        <= x_in;
            k        <= '0;
            zero_out <= 1'b0;
            sat_out  <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (x == '0) begin
            k_out     <= KMIN_V;
            m_out     <= '0;
            zero_out  <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (too_big && k != KMAX_V) begin
            x <= x_scaled;
            k <= k + K_W'(1);
          end else if (too_small && k != KMIN_V) begin
            x <= x_scaled;
            k <= k - K_W'(1);
          end else begin
            // In range, or pinned at an exponent limit while still out of range.
            k_out     <= k;
            m_out     <= x;
            sat_out   <= too_big | too_small;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_range_reduce.sv
// Directed bench for log_range_reduce with hand-computed expected results.
module tb_log_range_reduce;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  k_out;
  logic [15:0] m_out;
  logic        zero_out;
  logic        sat_out;

  int checks = 0;
  int errors = 0;

`ifdef LOG_RANGE_ROUND_EN
  localparam logic [15:0] M_FFFF = 16'h22A7;
  localparam logic [15:0] M_0001 = 16'h0CC9;
`else
  localparam logic [15:0] M_FFFF = 16'h22A6;
  localparam logic [15:0] M_0001 = 16'h0771;
`endif

  log_range_reduce #(.DATA_W(16), .K_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .k_out     (k_out),
    .m_out     (m_out),
    .zero_out  (zero_out),
    .sat_out   (sat_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input string tag, input logic [15:0] x);
    @(negedge clk);
    x_in = x;
    in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] x, input logic [3:0] ek,
                       input logic [15:0] em, input logic ez, input logic es, input int elat);
    int lat;
    start(tag, x);
    chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".k"}, 32'(k_out), 32'(ek));
    chk({tag, ".m"}, 32'(m_out), 32'(em));
    chk({tag, ".zero"}, 32'(zero_out), 32'(ez));
    chk({tag, ".sat"}, 32'(sat_out), 32'(es));
    handshake(tag);
  endtask

  initial begin
    int lat;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.k", 32'(k_out), 32'd0);
    chk("rst.m", 32'(m_out), 32'd0);
    chk("rst.zero", 32'(zero_out), 32'd0);
    chk("rst.sat", 32'(sat_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    do_op("one",  16'h1000, 4'h0, 16'h1000, 1'b0, 1'b0, 1);
    do_op("e",    16'h2B7E, 4'h1, 16'h1000, 1'b0, 1'b0, 2);
    do_op("half", 16'h0800, 4'hF, 16'h15BF, 1'b0, 1'b0, 2);
    do_op("max",  16'hFFFF, 4'h2, M_FFFF,   1'b0, 1'b0, 3);
    do_op("zero", 16'h0000, 4'h8, 16'h0000, 1'b1, 1'b0, 1);
    do_op("tiny", 16'h0001, 4'h8, M_0001,   1'b0, 1'b1, 9);
    do_op("one2", 16'h1000, 4'h0, 16'h1000, 1'b0, 1'b0, 1);

    // Back-pressure: result must hold while out_ready stays low.
    start("hold", 16'h2B7E);
    wait_valid(lat);
    chk("hold.latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.k", 32'(k_out), 32'd1);
      chk("hold.m", 32'(m_out), 32'h1000);
    end
    handshake("hold");

    // Reset in the middle of a long reduction.
    start("mid", 16'h0001);
    repeat (3) @(posedge clk);
    #1;
    chk("mid.busy_ov", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.in_ready", 32'(in_ready), 32'd0);
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.k", 32'(k_out), 32'd0);
    chk("mid.m", 32'(m_out), 32'd0);
    chk("mid.zero", 32'(zero_out), 32'd0);
    chk("mid.sat", 32'(sat_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.in_ready_after", 32'(in_ready), 32'd1);
    chk("mid.out_valid_after", 32'(out_valid), 32'd0);

    do_op("post", 16'h0800, 4'hF, 16'h15BF, 1'b0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/log_range_reduce.md
# log_range_reduce

Sequential range-reduction unit for fixed-point natural-log and exponent evaluation in the 16-bit fractional PE. Accepts an unsigned Q4.12 magnitude and iteratively scales it by e or 1/e until it lies in [1, e). Returns the signed integer exponent k and the residual mantissa m, with x ≈ m·e^k. Its k output uses the same 4-bit two's-complement exponent encoding that the PE's exponent-scale lookup consumes, so it sits ahead of that lookup on the inverse path.

## Interface
Parameters:
- DATA_W, 16, width of x and m (Q4.12 format, so 1.0 = 16'h1000)
- K_W, 4, width of the signed exponent (range −8..+7)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operand valid
- in_ready  out  1  unit idle and able to accept an operand
- x_in  in  DATA_W  operand, unsigned Q4.12
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- k_out  out  K_W  integer exponent, two's complement
- m_out  out  DATA_W  residual mantissa, unsigned Q4.12
- zero_out  out  1  operand was zero
- sat_out  out  1  k clamped at −8 or +7 with m still outside [1, e)

## Operation
- Constants: E_Q12 = 16'h2B7E (e) and INV_E_Q12 = 16'h05E3 (1/e).
- Scale step: the 16×16 product is shifted right 12 and its low DATA_W bits are kept. No overflow occurs in either scaling direction.
- States: S_IDLE, S_RUN, S_DONE.
- S_IDLE:
  - in_ready = 1.
  - When in_valid is high: load x ← x_in, k ← 0, clear the flags, go to S_RUN.
- S_RUN (one decision per cycle, in this priority order):
  - x == 0: k ← −8, m ← 0, zero ← 1, go to S_DONE.
  - x ≥ E_Q12 and k < 7: x ← x·INV_E_Q12, k ← k+1.
  - x ≥ E_Q12 and k == 7: sat ← 1, go to S_DONE.
  - x < 16'h1000 and k > −8: x ← x·E_Q12, k ← k−1.
  - x < 16'h1000 and k == −8: sat ← 1, go to S_DONE.
  - Otherwise (x in range): go to S_DONE.
- S_DONE:
  - out_valid = 1.
  - k_out, m_out and the flags hold steady until out_ready is high, then go to S_IDLE.
- No new operand is accepted while in S_RUN or S_DONE; in_ready is low there.

## Timing
- Reset values: in_ready 0 during reset and 1 after; out_valid 0; k_out 0; m_out 0; zero_out 0; sat_out 0; state S_IDLE.
- Latency: out_valid rises |k|+1 clock edges after the accepting edge, so an in-range operand gives 1 edge.
- Zero operand: fixed latency of 1 edge.
- Throughput: one operand per |k|+3 cycles at best (accept, RUN steps, DONE handshake, IDLE).
- The output handshake completes on any edge where out_valid and out_ready are both high. in_ready reasserts on the following cycle.
- Reset mid-operation: all state and outputs return to their reset values immediately, and the partial result is discarded.

## Configuration
- LOG_RANGE_ROUND_EN defined: each scale step rounds to nearest by adding 2^11 before the shift.
- LOG_RANGE_ROUND_EN undefined: each scale step truncates.
- Latency and the FSM are identical in both builds.

## Structure
- Shared package log_range_pkg holds:
  - E_Q12, INV_E_Q12, ONE_Q12
  - the state enum
  - K_MIN / K_MAX
- One sub-module, q12_const_mul: a combinational multiply of an operand by a Q4.12 constant, containing the rounding option. It is instantiated once, with the constant muxed by scaling direction.

## Test plan
- x_in=16'h1000 → k=0, m=16'h1000, flags 0, out_valid 1 edge after accept.
- x_in=16'h2B7E → k=1, m=16'h1000 in both builds, latency 2.
- x_in=16'h0800 → k=−1 (4'hF), m=16'h15BF, latency 2.
- x_in=16'hFFFF → k=2, latency 3; m=16'h22A6 truncating, 16'h22A7 with LOG_RANGE_ROUND_EN.
- Edge cases:
  - x_in=0 → k=−8 (4'h8), m=0, zero_out=1, latency 1.
  - x_in=16'h0001 → k=−8, sat_out=1.
- Handshake: hold out_ready low for 5 cycles → outputs stable and in_ready low throughout. Then assert rst_n low during S_RUN → all outputs at reset values.
